// File: rtl/rep_code_tx_if.sv
// rep_code_tx_if: word handshake and serial chip stream of rep_code_tx.
interface rep_code_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data;
  logic valid;
  logic ready;
  logic txd;
  logic busy;
  logic done;
  modport master (output data, valid, input ready, txd, busy, done);
  modport slave (input data, valid, output ready, txd, busy, done);
endinterface

// File: rtl/rep_code_tx.sv
// rep_code_tx: repetition-code serial transmitter, each frame bit sent as REP chips of DIV clocks.
// Define REP_CODE_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rep_code_tx #(
  parameter int DATA_W = 8,
  parameter int REP = 3,
  parameter int DIV = 4
) (
  input logic clk,
  input logic rst,
  rep_code_tx_if.slave bus
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = REP > 1 ? $clog2(REP) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
`ifdef REP_CODE_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  state_t state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [CW-1:0] chip_cnt, chip_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic txd, busy, done;
  logic txd_n, busy_n, done_n;
  logic accept, chip_end, bit_end;
`ifdef REP_CODE_TX_PARITY_EN
  logic par, par_n;
`endif
  assign bus.ready = state == S_IDLE && !rst;
  assign bus.txd = txd;
  assign bus.busy = busy;
  assign bus.done = done;
  assign accept = bus.ready && bus.valid;
  assign chip_end = div_cnt == DIV_LAST;
  assign bit_end = chip_end && chip_cnt == CHIP_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      div_cnt <= '0;
      chip_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      txd <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef REP_CODE_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      div_cnt <= div_n;
      chip_cnt <= chip_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      txd <= txd_n;
      busy <= busy_n;
      done <= done_n;
`ifdef REP_CODE_TX_PARITY_EN
      par <= par_n;
`endif
    end
  always_comb begin
    div_n = (state == S_IDLE || chip_end) ? '0 : div_cnt + 1'b1;
    chip_n = (state == S_IDLE || bit_end) ? '0 : chip_cnt + CW'(chip_end);
    bit_n = state != S_DATA ? '0 : !bit_end ? bit_cnt : bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
    shift_n = accept ? bus.data : (state == S_DATA && bit_end) ? shift >> 1 : shift;
`ifdef REP_CODE_TX_PARITY_EN
    par_n = accept ? ^bus.data : par;
`endif
    state_n = state;
    case (state)
      S_IDLE: state_n = accept ? S_START : S_IDLE;
      S_START: state_n = bit_end ? S_DATA : S_START;
`ifdef REP_CODE_TX_PARITY_EN
      S_DATA: state_n = (bit_end && bit_cnt == BIT_LAST) ? S_PARITY : S_DATA;
      S_PARITY: state_n = bit_end ? S_STOP : S_PARITY;
`else
      S_DATA: state_n = (bit_end && bit_cnt == BIT_LAST) ? S_STOP : S_DATA;
`endif
      S_STOP: state_n = bit_end ? S_IDLE : S_STOP;
      default: state_n = S_IDLE;
    endcase
  end
  // Outputs are registered, so they are derived from the upcoming state and counters.
  always_comb begin
    busy_n = state_n != S_IDLE;
    done_n = state_n == S_STOP && div_n == DIV_LAST && chip_n == CHIP_LAST;
    txd_n = state_n == S_START ? 1'b0 :
            state_n == S_DATA ? shift_n[0] :
`ifdef REP_CODE_TX_PARITY_EN
            state_n == S_PARITY ? par_n :
`endif
            1'b1;
  end
endmodule

// File: tb/tb_rep_code_tx.sv
// tb_rep_code_tx: directed scoreboard bench for rep_code_tx (default, NRZ and majority-vote loopback instances).
module tb_rep_code_tx;
  localparam int W = 8;
`ifdef REP_CODE_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [W-1:0] word_q[$];
  always #5 clk = ~clk;
  rep_code_tx_if #(.DATA_W(W)) b0 ();
  rep_code_tx_if #(.DATA_W(W)) b1 ();
  rep_code_tx_if #(.DATA_W(W)) b2 ();
  rep_code_tx #(.DATA_W(W), .REP(3), .DIV(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rep_code_tx #(.DATA_W(W), .REP(1), .DIV(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  rep_code_tx #(.DATA_W(W), .REP(3), .DIV(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  function automatic logic fbit(input logic [W-1:0] d, input int i);
    return i == 0 ? 1'b0 : i <= W ? d[i-1] : i == NB - 1 ? 1'b1 : ^d;
  endfunction
  function automatic logic [2:0] obs(input int s);
    return s == 0 ? {b0.txd, b0.busy, b0.done} : s == 1 ? {b1.txd, b1.busy, b1.done} : {b2.txd, b2.busy, b2.done};
  endfunction
  function automatic logic rdy(input int s);
    return s == 0 ? b0.ready : s == 1 ? b1.ready : b2.ready;
  endfunction
  task automatic drive(input int s, input logic v, input logic [W-1:0] d);
    if (s == 0) begin b0.valid = v; b0.data = d; end
    else if (s == 1) begin b1.valid = v; b1.data = d; end
    else begin b2.valid = v; b2.data = d; end
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic push_frame(input logic [W-1:0] d, input int rep, input int div);
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < rep * div; j++)
        exp_q.push_back({fbit(d, i), 1'b1, i == NB - 1 && j == rep * div - 1});
  endtask
  task automatic step_check(input int s, input string tag);
    logic [2:0] e;
    @(posedge clk);
    #1;
    e = exp_q.size() == 0 ? 3'b100 : exp_q.pop_front();
    chk({tag, " txd/busy/done"}, 32'(obs(s)), 32'(e));
  endtask
  task automatic send(input int s, input logic [W-1:0] d, input int rep, input int div, input string tag);
    drive(s, 1'b1, d);
    push_frame(d, rep, div);
    step_check(s, tag);
    drive(s, 1'b0, d);
    chk({tag, " ready_busy"}, 32'(rdy(s)), 32'd0);
    while (exp_q.size() > 0) step_check(s, tag);
    step_check(s, {tag, "_idle"});
    chk({tag, " ready_after"}, 32'(rdy(s)), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    logic [NB*3-1:0] chips;
    logic [NB-1:0] rec, expv;
    logic [W-1:0] w;
    logic got_done;
    int k;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b1, 8'h55);
    #12;
    chk("reset txd/busy/done", 32'(obs(0)), 32'h4);
    chk("reset ready", 32'(rdy(0)), 32'd0);
    drive(2, 1'b0, '0);
    rst = 1'b0;
    #1;
    chk("release ready", 32'(rdy(0)), 32'd1);
    send(0, 8'hA5, 3, 4, "a5");
    // Word held valid through a frame: accepted only at the first IDLE edge.
    drive(0, 1'b1, 8'hA5);
    push_frame(8'hA5, 3, 4);
    exp_q.push_back(3'b100);
    push_frame(8'h3C, 3, 4);
    for (int n = 1; exp_q.size() > 0; n++) begin
      step_check(0, "b2b");
      if (n == 1) drive(0, 1'b1, 8'h3C);
      if (n == NB * 12 + 1) chk("b2b ready_gap", 32'(rdy(0)), 32'd1);
      if (n == NB * 12 + 2) drive(0, 1'b0, 8'h3C);
    end
    step_check(0, "b2b_idle");
    drive(0, 1'b1, 8'hFF);
    push_frame(8'hFF, 3, 4);
    step_check(0, "ff");
    drive(0, 1'b0, 8'hFF);
    for (int n = 2; n <= 50; n++) step_check(0, "ff");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst txd/busy/done", 32'(obs(0)), 32'h4);
    chk("midrst ready", 32'(rdy(0)), 32'd0);
    exp_q.delete();
    step_check(0, "midrst_hold");
    step_check(0, "midrst_hold");
    rst = 1'b0;
    send(0, 8'h01, 3, 4, "01");
    send(1, 8'h00, 1, 1, "nrz00");
    send(0, 8'h07, 3, 4, "p07");
    for (int v = 0; v < 256; v++) begin
      w = W'(v);
      word_q.push_back(w);
      drive(2, 1'b1, w);
      got_done = 1'b0;
      for (int c = 0; c < NB * 3; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) drive(2, 1'b0, w);
        chips[c] = b2.txd;
        if (c == NB * 3 - 1) got_done = b2.done;
      end
      chk("loop done", 32'(got_done), 32'd1);
      w = word_q.pop_front();
      for (int g = 0; g < NB; g++) begin
        k = 3 * g + int'($urandom_range(0, 2));
        chips[k] = ~chips[k];
        rec[g] = (chips[3*g] & chips[3*g+1]) | (chips[3*g] & chips[3*g+2]) | (chips[3*g+1] & chips[3*g+2]);
        expv[g] = fbit(w, g);
      end
      chk("loopback", 32'(rec), 32'(expv));
      @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
